// File: rtl/systolic_mm_engine.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_mm_engine
//  Purpose  : N x N output-stationary systolic matrix multiplier computing
//             C = A*B or C += A*B. Operands arrive unskewed, one column of A
//             and one row of B per beat. The engine skews them internally and
//             drains the result row by row with backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_mm_engine #(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  signed_mode,
    input  logic                                  accum,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]          a_col,
    input  logic [N-1:0][DATA_WIDTH-1:0]          b_row,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N-1:0][OUTPUT_WIDTH-1:0]        out_row,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  out_row_idx,
    output logic                                  busy,
    output logic                                  done
);

    localparam int c_row_w  = (N > 1) ? $clog2(N) : 1;
    localparam int c_cnt_w  = $clog2(2 * N + 1);
    localparam int c_prod_w = 2 * DATA_WIDTH;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_drain  = 2'd2;
    localparam logic [1:0] c_st_output = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_row_w-1:0] r_row;
    logic               r_signed;
    logic               r_done;

    logic w_start_fire;
    logic w_en;
    logic w_last_beat;
    logic w_drain_end;
    logic w_last_row;

    assign w_start_fire = (r_state == c_st_idle) && start;
    // Global advance: a beat accepted in LOAD, or any DRAIN cycle (zeros in).
    assign w_en         = ((r_state == c_st_load) && in_valid) || (r_state == c_st_drain);
    assign w_last_beat  = (r_cnt == c_cnt_w'(N - 1));
    // Drain spans the capture stage, the skew, the array traversal and the
    // product register, so the last accumulate lands before OUTPUT opens.
    assign w_drain_end  = (r_cnt == c_cnt_w'(2 * N));
    assign w_last_row   = (r_row == c_row_w'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (start)                    w_next_state = c_st_load;
            c_st_load:   if (in_valid && w_last_beat)  w_next_state = c_st_drain;
            c_st_drain:  if (w_drain_end)              w_next_state = c_st_output;
            c_st_output: if (out_ready && w_last_row)  w_next_state = c_st_idle;
            default:                                   w_next_state = c_st_idle;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        in_ready  = (r_state == c_st_load);
        out_valid = (r_state == c_st_output);
        busy      = (r_state != c_st_idle);
    end

    // Beat/drain counter, row index, latched mode and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_row    <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_output) && out_ready && w_last_row;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_signed <= signed_mode;
                        r_cnt    <= '0;
                        r_row    <= '0;
                    end
                end
                c_st_load: begin
                    if (in_valid) begin
                        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
                    end
                end
                c_st_drain: begin
                    r_cnt <= w_drain_end ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    if (out_ready) begin
                        r_row <= w_last_row ? '0 : r_row + 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_row_idx = r_row;
    assign done        = r_done;

    // ------------------------------------------------------------------
    // Operand capture: one register per lane, zeros injected in DRAIN
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_a_cap [N];
    logic [DATA_WIDTH-1:0] r_b_cap [N];

    // Capture accepted operands into the lane registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || w_start_fire) begin
                r_a_cap[i] <= '0;
                r_b_cap[i] <= '0;
            end else if (w_en) begin
                r_a_cap[i] <= (r_state == c_st_load) ? a_col[i] : '0;
                r_b_cap[i] <= (r_state == c_st_load) ? b_row[i] : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skew: A row i and B column i each delayed by i enabled cycles
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_a_edge [N];
    logic [DATA_WIDTH-1:0] w_b_edge [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign w_a_edge[i] = r_a_cap[i];
            assign w_b_edge[i] = r_b_cap[i];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_a_sr [i];
            logic [DATA_WIDTH-1:0] r_b_sr [i];

            // Lane-local shift register, advancing only with the array
            always_ff @(posedge clk) begin
                if (rst || w_start_fire) begin
                    for (int s = 0; s < i; s++) begin
                        r_a_sr[s] <= '0;
                        r_b_sr[s] <= '0;
                    end
                end else if (w_en) begin
                    r_a_sr[0] <= r_a_cap[i];
                    r_b_sr[0] <= r_b_cap[i];
                    for (int s = 1; s < i; s++) begin
                        r_a_sr[s] <= r_a_sr[s-1];
                        r_b_sr[s] <= r_b_sr[s-1];
                    end
                end
            end

            assign w_a_edge[i] = r_a_sr[i-1];
            assign w_b_edge[i] = r_b_sr[i-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid: A flows right, B flows down, product registered then summed
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   r_a_pe     [N][N];
    logic [DATA_WIDTH-1:0]   r_b_pe     [N][N];
    logic [OUTPUT_WIDTH-1:0] r_prod     [N][N];
    logic [OUTPUT_WIDTH-1:0] r_acc      [N][N];
    logic [DATA_WIDTH-1:0]   w_a_in     [N][N];
    logic [DATA_WIDTH-1:0]   w_b_in     [N][N];
    logic [OUTPUT_WIDTH-1:0] w_prod_ext [N][N];

    for (genvar i = 0; i < N; i++) begin : g_pe_row
        for (genvar j = 0; j < N; j++) begin : g_pe_col
            logic [c_prod_w-1:0] w_prod_u;
            logic [c_prod_w-1:0] w_prod_s;

            if (j == 0) begin : g_a_from_skew
                assign w_a_in[i][j] = w_a_edge[i];
            end else begin : g_a_from_left
                assign w_a_in[i][j] = r_a_pe[i][j-1];
            end

            if (i == 0) begin : g_b_from_skew
                assign w_b_in[i][j] = w_b_edge[j];
            end else begin : g_b_from_above
                assign w_b_in[i][j] = r_b_pe[i-1][j];
            end

            // Both interpretations are formed; the latched mode picks one and
            // extends it to the accumulator width accordingly.
            assign w_prod_u = c_prod_w'(w_a_in[i][j]) * c_prod_w'(w_b_in[i][j]);
            assign w_prod_s = c_prod_w'($signed(w_a_in[i][j])) * c_prod_w'($signed(w_b_in[i][j]));
            assign w_prod_ext[i][j] = r_signed ? OUTPUT_WIDTH'($signed(w_prod_s))
                                               : OUTPUT_WIDTH'(w_prod_u);
        end
    end

    // Operand propagation, product pipeline and wrapping accumulation
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst) begin
                    r_a_pe[i][j] <= '0;
                    r_b_pe[i][j] <= '0;
                    r_prod[i][j] <= '0;
                    r_acc[i][j]  <= '0;
                end else if (w_start_fire) begin
                    r_a_pe[i][j] <= '0;
                    r_b_pe[i][j] <= '0;
                    r_prod[i][j] <= '0;
                    if (!accum) begin
                        r_acc[i][j] <= '0;
                    end
                end else if (w_en) begin
                    r_a_pe[i][j] <= w_a_in[i][j];
                    r_b_pe[i][j] <= w_b_in[i][j];
                    r_prod[i][j] <= w_prod_ext[i][j];
                    r_acc[i][j]  <= r_acc[i][j] + r_prod[i][j];
                end
            end
        end
    end

    // Result row mux, zero outside OUTPUT
    always_comb begin
        for (int j = 0; j < N; j++) begin
            out_row[j] = '0;
        end
        if (r_state == c_st_output) begin
            for (int j = 0; j < N; j++) begin
                out_row[j] = r_acc[r_row][j];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_mm_engine
//  Purpose  : Directed self-checking bench for systolic_mm_engine (N = 3),
//             with a 32-bit and a 16-bit result instance on shared stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_engine;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start, signed_mode, accum, in_valid, out_ready;
    logic [N-1:0][7:0]    a_col, b_row;
    logic                 in_ready, out_valid, busy, done;
    logic [N-1:0][31:0]   out_row;
    logic [1:0]           out_row_idx;
    logic                 in_ready16, out_valid16, busy16, done16;
    logic [N-1:0][15:0]   out_row16;
    logic [1:0]           out_row_idx16;

    systolic_mm_engine #(.N(N), .DATA_WIDTH(8), .OUTPUT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .accum(accum),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy), .done(done)
    );

    systolic_mm_engine #(.N(N), .DATA_WIDTH(8), .OUTPUT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .accum(accum),
        .in_valid(in_valid), .in_ready(in_ready16), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_row_idx(out_row_idx16), .busy(busy16), .done(done16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat;

    logic [7:0]  mat_a [N][N];
    logic [7:0]  mat_b [N][N];
    logic [31:0] res   [N][N];
    logic [15:0] res16 [N][N];
    logic [31:0] exp_c [N][N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic check_res(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), res[i][j], exp_c[i][j]);
    endtask

    task automatic fill_exp(input logic [31:0] v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_c[i][j] = v;
    endtask

    // One full run, entered and left on a falling edge; ends in the done cycle.
    task automatic run_mm(input logic sm, input logic ac, input int stall,
                          input bit toggle, input bit hold_start);
        int c0;
        int guard;
        int got;
        bit prev_stall;
        logic [N-1:0][31:0] prev_row;
        logic [1:0] prev_idx;
        c0 = 0;
        start = 1'b1; signed_mode = sm; accum = ac;
        @(negedge clk);
        start = 1'b0; signed_mode = ~sm; accum = ~ac;
        check("in_ready_load", in_ready, 1);
        check("done_low", done, 0);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_col[i] = mat_a[i][k];
                b_row[i] = mat_b[k][i];
            end
            @(negedge clk);
            if (k == 0) begin
                c0 = cyc;
                if (stall > 0) begin
                    in_valid = 1'b0; a_col = '1; b_row = '1;
                    repeat (stall) @(negedge clk);
                end
            end
        end
        in_valid = 1'b1; a_col = {N{8'h55}}; b_row = {N{8'h55}};
        out_ready = 1'b1; start = hold_start;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", out_valid, 1);
        lat = cyc - c0;
        in_valid = 1'b0; start = 1'b0;
        got = 0; prev_stall = 0; guard = 0;
        prev_row = '0; prev_idx = '0;
        while (got < N && guard < 60) begin
            if (prev_stall) begin
                check("row_stable", out_row, prev_row);
                check("idx_stable", out_row_idx, prev_idx);
            end
            if (toggle) out_ready = ~out_ready;
            if (out_valid && out_ready) begin
                check("row_order", out_row_idx, got);
                for (int j = 0; j < N; j++) begin
                    res[got][j]   = out_row[j];
                    res16[got][j] = out_row16[j];
                end
                got++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid;
                prev_row   = out_row;
                prev_idx   = out_row_idx;
            end
            guard++;
            @(negedge clk);
        end
        check("rows_done", got, N);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("out_valid_in_done", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; accum = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_row", out_row, 0);
        check("rst_row_idx", out_row_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Operand and result traffic without start must not wake the engine
        in_valid = 1'b1; out_ready = 1'b1; a_col = {N{8'h11}}; b_row = {N{8'h22}};
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_out_valid", out_valid, 0);
        in_valid = 1'b0;

        // A = [[1,2,3],[4,5,6],[7,8,9]], B = identity
        mat_a = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
        mat_b = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
        run_mm(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("latency_plain", lat, 9);
        exp_c = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
        check_res("ident");

        // Back-to-back accumulate run
        run_mm(1'b0, 1'b1, 0, 1'b0, 1'b0);
        exp_c = '{'{32'd2, 32'd4, 32'd6}, '{32'd8, 32'd10, 32'd12}, '{32'd14, 32'd16, 32'd18}};
        check_res("accum");

        run_mm(1'b0, 1'b0, 0, 1'b0, 1'b0);
        exp_c = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
        check_res("clear");

        // Two stall cycles after beat 0, out_ready toggling, start held mid-run
        run_mm(1'b0, 1'b0, 2, 1'b1, 1'b1);
        check("latency_stall", lat, 11);
        check_res("stall");

        // A all 0xFF, B all 2
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = 8'hFF;
                mat_b[i][j] = 8'h02;
            end
        run_mm(1'b1, 1'b0, 0, 1'b0, 1'b0);
        fill_exp(32'hFFFF_FFFA);
        check_res("signed");
        run_mm(1'b0, 1'b0, 0, 1'b0, 1'b0);
        fill_exp(32'd1530);
        check_res("unsigned");

        // A and B all 0xFF: 195075 full width, 64003 in the 16-bit instance
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat_b[i][j] = 8'hFF;
        run_mm(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("done16", done16, 1);
        fill_exp(32'd195075);
        check_res("ff32");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("ff16_c%0d%0d", i, j), res16[i][j], 16'd64003);

        // Abort in DRAIN with accum = 1 so stale sums would survive a weak reset
        mat_a = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
        mat_b = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
        @(negedge clk);
        start = 1'b1; accum = 1'b1; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_col[i] = mat_a[i][k];
                b_row[i] = mat_b[k][i];
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        run_mm(1'b0, 1'b1, 0, 1'b0, 1'b0);
        exp_c = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
        check_res("post_rst");
        @(negedge clk);
        check("done_single", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
